// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter between the fetch and load/store ports.
package mem_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [3:0] WEN_READ = 4'b0000;

  // Widths sized for the legal parameter ranges (STARVE_MAX <= 15, MEM_LATENCY <= 8).
  localparam int STARVE_W = 4;
  localparam int LAT_W    = 3;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Fairness counter: counts data grants that overtook a waiting fetch and raises force_i at the limit.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_grant,
  input  logic d_grant,
  input  logic i_req_valid,
  output logic force_i
);

  localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] cnt;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (i_grant) begin
      cnt <= '0;
    end else if (d_grant && i_req_valid && (cnt != CNT_MAX)) begin
      cnt <= cnt + STARVE_W'(1);
    end
  end

  assign force_i = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requests onto one single-port synchronous memory,
// one transaction at a time: IDLE -> ISSUE -> WAIT x MEM_LATENCY -> RESP.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req_valid,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_req_ready,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_rdata,

  input  logic              d_req_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  input  logic [3:0]        d_req_wen,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_rdata,

  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  logic [1:0]        state;
  logic              owner;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wen_q;
  logic [LAT_W-1:0]  wait_cnt;

  logic idle;
  logic force_i;
  logic i_grant;
  logic d_grant;
  logic last_wait;

  // Readies stay low while rst is held so nothing can be accepted during reset.
  assign idle        = (state == IDLE) && !rst;
  assign d_req_ready = idle && !(i_req_valid && force_i);
  assign i_req_ready = idle && (!d_req_valid || force_i);

  // The ready equations make these two mutually exclusive.
  assign i_grant = i_req_valid && i_req_ready;
  assign d_grant = d_req_valid && d_req_ready;

  assign last_wait = (state == WAIT) && (wait_cnt == '0);

  mem_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_grant     (i_grant),
    .d_grant     (d_grant),
    .i_req_valid (i_req_valid),
    .force_i     (force_i)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= OWN_I;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= WEN_READ;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_grant) begin
            owner   <= OWN_D;
            addr_q  <= d_req_addr;
            wdata_q <= d_req_wdata;
            wen_q   <= d_req_wen;
            state   <= ISSUE;
          end else if (i_grant) begin
            owner   <= OWN_I;
            addr_q  <= i_req_addr;
            wdata_q <= '0;
            wen_q   <= WEN_READ;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= LAT_W'(MEM_LATENCY - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - LAT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response data registers only update on capture, so they hold between transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_rsp_rdata <= '0;
      d_rsp_rdata <= '0;
    end else if (last_wait) begin
      if (owner == OWN_I) begin
        i_rsp_rdata <= mem_rdata;
      end else begin
        d_rsp_rdata <= (wen_q == WEN_READ) ? mem_rdata : '0;
      end
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_wen   = (state == ISSUE && owner == OWN_D) ? wen_q : WEN_READ;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign i_rsp_valid = (state == RESP) && (owner == OWN_I) && !rst;
  assign d_rsp_valid = (state == RESP) && (owner == OWN_D) && !rst;

  assign busy = (state != IDLE);

endmodule
